payload_endpoint_multi: RTL
===========================

Name: payload_endpoint_multi

Overview:
- Synthesizable, parametrised receive endpoint that drains packets from NCH router output ports.
- Packet format: DA, SA, LEN, LEN payload bytes, FCS.
- Per channel, it handshakes with ready/read, checks DA against the configured port address, checks the XOR frame check and the length, and keeps saturating packet and error counters.
- Replaces the fixed 4-port testbench-side receiver. Sits on the router output side, both in the bench environment and as an on-chip self-check monitor.

Parameters:
- NCH, 4, number of output channels (1..16).
- DW, 8, byte/data width in bits; LEN field is DW bits.
- CNT_W, 16, width of each per-channel counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  allows new packets to start; an in-flight packet always completes.
- port_addr  in  NCH*DW  expected DA per channel; channel i uses slice [i*DW +: DW].
- ready  in  NCH  router has data for channel i.
- data  in  NCH*DW  channel byte; valid when read[i] and ready[i] are both 1.
- read  out  NCH  registered read request per channel.
- busy  out  NCH  channel is in RECV.
- pkt_done  out  NCH  one-cycle pulse when a packet finishes.
- err_da  out  NCH  last packet's DA != port_addr.
- err_fcs  out  NCH  last packet's XOR check failed.
- err_len  out  NCH  last packet's byte count != LEN+4, or runt.
- pkt_cnt  out  NCH*CNT_W  packets completed.
- err_cnt  out  NCH*CNT_W  packets with at least one error.

Behaviour:
- Reset (synchronous, active-high): at the reset edge all outputs go to 0, all counters go to 0, and every channel FSM goes to IDLE. This includes reset mid-packet; the partial packet is discarded with no pulse and no count.
- Channels are fully independent; the same rules apply to each channel i.
- Transfer rule: a byte transfers at a rising edge where read[i]==1 and ready[i]==1.
- FSM IDLE:
  - read=0.
  - If enable && ready[i]: read<=1, clear byte count and XOR accumulator, go to RECV.
  - First byte transfers no earlier than the following edge (1-cycle start latency).
- FSM RECV:
  - On each transfer: store byte 0 as DA and byte 2 as LEN; accumulate XOR of all bytes; increment the byte counter.
  - Byte counter is DW+3 bits and saturates; saturation forces err_len.
- End of packet: first edge in RECV with ready[i]==0. At that edge:
  - read<=0, pkt_done<=1 for exactly one cycle, go to IDLE.
  - err_len = (count<4) || (count != LEN+4).
  - err_da = (count>=1) && (DA != port_addr slice).
  - err_fcs = (count>=4) && (XOR of all bytes != 0).
  - Flags update only at pkt_done and hold until the next pkt_done.
- ready drop before the first transfer (count==0): treated as a runt; err_len=1, packet counted.
- Counters:
  - pkt_cnt increments by 1 per pkt_done.
  - err_cnt increments when any flag is set.
  - Both saturate at all-ones; no wrap.
- enable deassert: RECV continues to the end of packet; IDLE does not start a new packet.
- Back-to-back packets: ready held high across two packets is indistinguishable from one long packet, so it is flagged err_len. The router must drop ready for at least 1 cycle between packets.
- ready toggling while IDLE and enable==0: ignored.
- Arithmetic: LEN+4 is computed in DW+3 bits. LEN=0 means a 4-byte packet.

Decomposition:
- Shared package endpoint_pkg:
  - state enum {IDLE, RECV}.
  - constants PKT_OVERHEAD=4, DA_IDX=0, SA_IDX=1, LEN_IDX=2.
  - result struct {err_da, err_fcs, err_len}.
- One sub-module payload_endpoint_chan, holding the per-channel FSM, checks and counters. Top level generates NCH instances and slices the flattened buses.

Test Plan:
- Reset, then a single packet on channel 2 with port_addr[2]=8'h02: bytes 02,11,03,AA,BB,CC,FCS=XOR → pkt_done[2] for 1 cycle, all flags 0, pkt_cnt[2]=1, err_cnt[2]=0, read[2] low the cycle after ready falls.
- Same packet with FCS byte inverted → err_fcs=1, err_cnt=1; DA=8'h03 on channel 2 → err_da=1.
- LEN=5 but ready drops after 6 bytes → err_len=1. LEN=0, 4 correct bytes → no error.
- Four channels receiving concurrently with different lengths (0, 1, 17, 255) → independent pulses, each pkt_cnt=1, no cross-channel interference.
- enable dropped mid-packet on channel 0 → packet completes with pkt_done; a subsequent ready gets no read until enable returns. Reset asserted mid-packet → read=0 and counters=0 after the edge, no pulse.
- CNT_W=4: 17 packets → pkt_cnt saturates at 15. DW=16, NCH=1 build passes a 4-word packet.

Source files
------------

// File: rtl/payload_endpoint_multi_pkg.sv
// Shared types and constants for the multi-channel packet receive endpoint.
// Packet layout: DA, SA, LEN, LEN payload bytes, FCS (XOR of all bytes is zero).
package endpoint_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam int unsigned PKT_OVERHEAD = 4;
    localparam int unsigned DA_IDX       = 0;
    localparam int unsigned SA_IDX       = 1;
    localparam int unsigned LEN_IDX      = SA_IDX + 1;

    typedef struct packed {
        logic err_da;
        logic err_fcs;
        logic err_len;
    } result_t;

    function automatic logic any_err(input result_t r);
        return r.err_da | r.err_fcs | r.err_len;
    endfunction

endpackage

// File: rtl/payload_endpoint_multi_chan.sv
// One receive channel: ready/read handshake, DA/LEN/XOR checks at end of packet,
// and saturating packet/error counters.
module payload_endpoint_chan
    import endpoint_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [DW-1:0]    port_addr,
    input  logic             ready,
    input  logic [DW-1:0]    data,
    output logic             read,
    output logic             busy,
    output logic             pkt_done,
    output logic             err_da,
    output logic             err_fcs,
    output logic             err_len,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned BW = DW + 3;
    localparam logic [BW-1:0] OVH   = BW'(PKT_OVERHEAD);
    localparam logic [BW-1:0] ONE   = BW'(1);
    localparam logic [BW-1:0] I_DA  = BW'(DA_IDX);
    localparam logic [BW-1:0] I_LEN = BW'(LEN_IDX);

    state_t        state;
    logic [BW-1:0] byte_cnt;
    logic [DW-1:0] fcs_acc;
    logic [DW-1:0] da_q;
    logic [DW-1:0] len_q;
    result_t       res;

    assign busy = (state == RECV);

    // A saturated byte count can never equal LEN+4, but it is flagged explicitly.
    always_comb begin
        res         = '0;
        res.err_len = (byte_cnt < OVH) || (byte_cnt != ({3'b000, len_q} + OVH))
                      || (byte_cnt == '1);
        res.err_da  = (byte_cnt >= ONE) && (da_q != port_addr);
        res.err_fcs = (byte_cnt >= OVH) && (fcs_acc != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            read     <= 1'b0;
            pkt_done <= 1'b0;
            byte_cnt <= '0;
            fcs_acc  <= '0;
            da_q     <= '0;
            len_q    <= '0;
            err_da   <= 1'b0;
            err_fcs  <= 1'b0;
            err_len  <= 1'b0;
            pkt_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            pkt_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && ready) begin
                        read     <= 1'b1;
                        byte_cnt <= '0;
                        fcs_acc  <= '0;
                        state    <= RECV;
                    end
                end
                RECV: begin
                    if (!ready) begin
                        read     <= 1'b0;
                        pkt_done <= 1'b1;
                        {err_da, err_fcs, err_len} <= res;
                        if (pkt_cnt != '1)
                            pkt_cnt <= pkt_cnt + CNT_W'(1);
                        if (any_err(res) && (err_cnt != '1))
                            err_cnt <= err_cnt + CNT_W'(1);
                        state    <= IDLE;
                    end else if (read) begin
                        if (byte_cnt == I_DA)
                            da_q <= data;
                        if (byte_cnt == I_LEN)
                            len_q <= data;
                        fcs_acc <= fcs_acc ^ data;
                        if (byte_cnt != '1)
                            byte_cnt <= byte_cnt + ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/payload_endpoint_multi.sv
// Receive endpoint draining NCH router output ports; one independent channel
// per port, with flattened per-channel buses sliced into each instance.
module payload_endpoint_multi #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NCH*DW-1:0]    port_addr,
    input  logic [NCH-1:0]       ready,
    input  logic [NCH*DW-1:0]    data,
    output logic [NCH-1:0]       read,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       pkt_done,
    output logic [NCH-1:0]       err_da,
    output logic [NCH-1:0]       err_fcs,
    output logic [NCH-1:0]       err_len,
    output logic [NCH*CNT_W-1:0] pkt_cnt,
    output logic [NCH*CNT_W-1:0] err_cnt
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        payload_endpoint_chan #(
            .DW    (DW),
            .CNT_W (CNT_W)
        ) u_chan (
            .clock     (clock),
            .reset     (reset),
            .enable    (enable),
            .port_addr (port_addr[i*DW +: DW]),
            .ready     (ready[i]),
            .data      (data[i*DW +: DW]),
            .read      (read[i]),
            .busy      (busy[i]),
            .pkt_done  (pkt_done[i]),
            .err_da    (err_da[i]),
            .err_fcs   (err_fcs[i]),
            .err_len   (err_len[i]),
            .pkt_cnt   (pkt_cnt[i*CNT_W +: CNT_W]),
            .err_cnt   (err_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule
